// File: rtl/mac_pkg.sv
// Shared constants and helpers for the multiply-accumulate processing element.
package mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;

  // Saturation limits for a signed accumulator of width w.
  function automatic longint acc_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint acc_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint ACC_MAX = acc_max(ACC_W_DEF);
  localparam longint ACC_MIN = acc_min(ACC_W_DEF);

  // A sum carried one bit wider than its operands overflowed when its two top bits differ.
  function automatic logic sum_ovf(input logic [1:0] top2);
    return top2[1] ^ top2[0];
  endfunction

endpackage

// File: rtl/mac_pe_if.sv
// Operand, forwarding and result-chain signals of one processing element.
interface mac_pe_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              drain;
  logic              shift_en;
  logic [ACC_W-1:0]  res_in;
  logic              res_valid_in;
  logic [ACC_W-1:0]  res_out;
  logic              res_valid_out;
  logic              ovf_out;

  modport master (
    output in_valid, in_a, in_b, drain, shift_en, res_in, res_valid_in,
    input  out_valid, out_a, out_b, res_out, res_valid_out, ovf_out
  );

  modport slave (
    input  in_valid, in_a, in_b, drain, shift_en, res_in, res_valid_in,
    output out_valid, out_a, out_b, res_out, res_valid_out, ovf_out
  );

endinterface

// File: rtl/add2c_sat.sv
// Combinational two's-complement adder with optional clamping on overflow.
module add2c_sat
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter bit SAT   = 1'b1
)(
  input  logic [ACC_W-1:0] x,
  input  logic [ACC_W-1:0] y,
  output logic [ACC_W-1:0] z,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] sum;

  assign sum = {x[ACC_W-1], x} + {y[ACC_W-1], y};
  assign ovf = sum_ovf(sum[ACC_W -: 2]);

  // The sign of the wide sum tells which rail an overflowing result belongs on.
  always_comb begin
    z = sum[ACC_W-1:0];
    if (SAT && ovf) begin
      z = sum[ACC_W] ? SAT_LO : SAT_HI;
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Output-stationary systolic MAC element: forwards operands east/south, accumulates
// their product, and hands finished tiles to a shift chain through a result buffer.
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SAT    = 1'b1
)(
  input logic   clk,
  input logic   reset,
  mac_pe_if.slave bus
);

  logic [DATA_W-1:0]          a_q;
  logic [DATA_W-1:0]          b_q;
  logic                       v_q;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           p_q;
  logic                       p_v;
  logic [ACC_W-1:0]           acc;
  logic                       ovf;
  logic [ACC_W-1:0]           sum;
  logic                       add_ovf;
  logic [ACC_W-1:0]           nxt_or_acc;
  logic                       ovf_now;
  logic [ACC_W-1:0]           res;
  logic                       res_v;
  logic                       res_ovf;

  assign prod = $signed(bus.in_a) * $signed(bus.in_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
      p_q <= '0;
      p_v <= 1'b0;
    end else begin
      a_q <= bus.in_a;
      b_q <= bus.in_b;
      v_q <= bus.in_valid;
      p_v <= bus.in_valid;
      if (bus.in_valid) begin
        p_q <= ACC_W'(prod);
      end
    end
  end

  add2c_sat #(.ACC_W(ACC_W), .SAT(SAT)) u_add (
    .x   (acc),
    .y   (p_q),
    .z   (sum),
    .ovf (add_ovf)
  );

  assign nxt_or_acc = p_v ? sum : acc;
  assign ovf_now    = ovf | (p_v & add_ovf);

  // Drain takes the in-flight product with the closing tile and wins over a chain shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      ovf     <= 1'b0;
      res     <= '0;
      res_v   <= 1'b0;
      res_ovf <= 1'b0;
    end else if (bus.drain) begin
      res     <= nxt_or_acc;
      res_ovf <= ovf_now;
      res_v   <= 1'b1;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      acc <= nxt_or_acc;
      ovf <= ovf_now;
      if (bus.shift_en) begin
        res     <= bus.res_in;
        res_v   <= bus.res_valid_in;
        res_ovf <= 1'b0;
      end
    end
  end

  assign bus.out_a         = a_q;
  assign bus.out_b         = b_q;
  assign bus.out_valid     = v_q;
  assign bus.res_out       = res;
  assign bus.res_valid_out = res_v;
  assign bus.ovf_out       = res_ovf;

endmodule

// File: tb/tb_mac_pe.sv
// Drives three mac_pe configurations (20-bit saturating, 16-bit saturating, 16-bit wrapping)
// with one stimulus stream and compares them to directed vectors and an arithmetic model.
module tb_mac_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        drain;
  logic        shift_en;
  logic [19:0] res_in;
  logic        res_valid_in;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mac_pe_if #(.DATA_W(8), .ACC_W(20)) if0 ();
  mac_pe_if #(.DATA_W(8), .ACC_W(16)) if1 ();
  mac_pe_if #(.DATA_W(8), .ACC_W(16)) if2 ();

  assign if0.in_valid = in_valid;      assign if1.in_valid = in_valid;      assign if2.in_valid = in_valid;
  assign if0.in_a = in_a;              assign if1.in_a = in_a;              assign if2.in_a = in_a;
  assign if0.in_b = in_b;              assign if1.in_b = in_b;              assign if2.in_b = in_b;
  assign if0.drain = drain;            assign if1.drain = drain;            assign if2.drain = drain;
  assign if0.shift_en = shift_en;      assign if1.shift_en = shift_en;      assign if2.shift_en = shift_en;
  assign if0.res_in = res_in;          assign if1.res_in = res_in[15:0];    assign if2.res_in = res_in[15:0];
  assign if0.res_valid_in = res_valid_in;
  assign if1.res_valid_in = res_valid_in;
  assign if2.res_valid_in = res_valid_in;

  mac_pe #(.DATA_W(8), .ACC_W(20), .SAT(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mac_pe #(.DATA_W(8), .ACC_W(16), .SAT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  mac_pe #(.DATA_W(8), .ACC_W(16), .SAT(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        drn;
    logic        shf;
    logic [19:0] rin;
    logic        rvi;
    bit          chk;
    longint      r0;
    longint      r1;
    longint      r2;
    logic        rv;
    logic [2:0]  ovf;
  } vec_t;

  vec_t tbl[29];

  // Reference model: plain integer arithmetic per configuration
  int     width[3] = '{20, 16, 16};
  bit     satc[3]  = '{1'b1, 1'b1, 1'b0};
  longint m_acc[3], m_res[3];
  bit     m_ovf[3], m_ovo[3], m_rv[3];
  longint pend_p = 0;
  bit     pend_v = 1'b0;
  longint fa = 0, fb = 0;
  bit     fv = 1'b0;

  function automatic vec_t mk(input logic rst, input logic vld, input logic [7:0] a, input logic [7:0] b,
                              input logic drn, input logic shf, input logic [19:0] rin, input logic rvi,
                              input bit chk, input longint r0, input longint r1, input longint r2,
                              input logic rv, input logic [2:0] ovf);
    vec_t v;
    v.rst = rst; v.vld = vld; v.a = a; v.b = b; v.drn = drn; v.shf = shf;
    v.rin = rin; v.rvi = rvi; v.chk = chk; v.r0 = r0; v.r1 = r1; v.r2 = r2;
    v.rv = rv; v.ovf = ovf;
    return v;
  endfunction

  function automatic longint fit(input longint s, input int w, input bit sat, output bit ov);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -hi - 1;
    longint span = longint'(1) <<< w;
    ov = 1'b0;
    if (s > hi) begin
      ov = 1'b1;
      return sat ? hi : s - span;
    end
    if (s < lo) begin
      ov = 1'b1;
      return sat ? lo : s + span;
    end
    return s;
  endfunction

  function automatic longint as_signed(input logic [19:0] v, input int w);
    longint span = longint'(1) <<< w;
    longint m = longint'(v) % span;
    if (m >= span / 2) m = m - span;
    return m;
  endfunction

  task automatic modelStep();
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0; m_res[k] = 0; m_ovf[k] = 0; m_ovo[k] = 0; m_rv[k] = 0;
      end
      pend_p = 0; pend_v = 0; fa = 0; fb = 0; fv = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        longint nxt = m_acc[k];
        bit ov = 1'b0;
        if (pend_v) nxt = fit(m_acc[k] + pend_p, width[k], satc[k], ov);
        if (drain) begin
          m_res[k] = nxt; m_ovo[k] = m_ovf[k] | ov; m_rv[k] = 1'b1;
          m_acc[k] = 0;   m_ovf[k] = 1'b0;
        end else begin
          m_acc[k] = nxt;
          m_ovf[k] = m_ovf[k] | ov;
          if (shift_en) begin
            m_res[k] = as_signed(res_in, width[k]);
            m_rv[k]  = res_valid_in;
            m_ovo[k] = 1'b0;
          end
        end
      end
      pend_v = in_valid;
      if (in_valid) pend_p = longint'($signed(in_a)) * longint'($signed(in_b));
      fa = longint'(in_a); fb = longint'(in_b); fv = in_valid;
    end
  endtask

  task automatic compareVal(input string name, input int k, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0d, expected %0d", name, k, $time, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [7:0] a, input logic [7:0] b,
                               input logic drn, input logic shf, input logic [19:0] rin, input logic rvi);
    reset = rst; in_valid = vld; in_a = a; in_b = b;
    drain = drn; shift_en = shf; res_in = rin; res_valid_in = rvi;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic dutValues(input int k, output longint r, output longint rv, output longint ov,
                           output longint oa, output longint ob, output longint v);
    case (k)
      0: begin r = longint'($signed(if0.res_out)); rv = longint'(if0.res_valid_out); ov = longint'(if0.ovf_out);
               oa = longint'(if0.out_a); ob = longint'(if0.out_b); v = longint'(if0.out_valid); end
      1: begin r = longint'($signed(if1.res_out)); rv = longint'(if1.res_valid_out); ov = longint'(if1.ovf_out);
               oa = longint'(if1.out_a); ob = longint'(if1.out_b); v = longint'(if1.out_valid); end
      default: begin r = longint'($signed(if2.res_out)); rv = longint'(if2.res_valid_out); ov = longint'(if2.ovf_out);
               oa = longint'(if2.out_a); ob = longint'(if2.out_b); v = longint'(if2.out_valid); end
    endcase
  endtask

  task automatic checkOutput();
    longint r, rv, ov, oa, ob, v;
    for (int k = 0; k < 3; k++) begin
      dutValues(k, r, rv, ov, oa, ob, v);
      compareVal("res_out", k, r, m_res[k]);
      compareVal("res_valid_out", k, rv, longint'(m_rv[k]));
      compareVal("ovf_out", k, ov, longint'(m_ovo[k]));
      compareVal("out_a", k, oa, fa);
      compareVal("out_b", k, ob, fb);
      compareVal("out_valid", k, v, longint'(fv));
    end
  endtask

  task automatic checkTable(input vec_t t);
    longint r, rv, ov, oa, ob, v;
    longint er[3];
    er[0] = t.r0; er[1] = t.r1; er[2] = t.r2;
    for (int k = 0; k < 3; k++) begin
      dutValues(k, r, rv, ov, oa, ob, v);
      compareVal("tbl_res", k, r, er[k]);
      compareVal("tbl_res_valid", k, rv, longint'(t.rv));
      compareVal("tbl_ovf", k, ov, longint'(t.ovf[k]));
    end
  endtask

  initial begin
    //               rst vld a      b      drn shf rin       rvi chk r0      r1      r2      rv ovf(dut2..0)
    tbl[0]  = mk(1, 0, 8'h00, 8'h00, 0, 0, 20'h0,     0, 1, 0,      0,      0,      0, 3'b000);
    tbl[1]  = mk(0, 1, 8'h03, 8'hFC, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[2]  = mk(0, 1, 8'h05, 8'h06, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[3]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 20'h0,     0, 1, 18,     18,     18,     1, 3'b000);
    tbl[4]  = mk(0, 1, 8'h80, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[5]  = mk(0, 1, 8'h80, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[6]  = mk(0, 1, 8'h80, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[7]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 20'h0,     0, 1, 49152,  32767,  -16384, 1, 3'b110);
    tbl[8]  = mk(0, 1, 8'h02, 8'h03, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[9]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[10] = mk(0, 0, 8'h00, 8'h00, 1, 0, 20'h0,     0, 1, 6,      6,      6,      1, 3'b000);
    tbl[11] = mk(0, 1, 8'h80, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[12] = mk(0, 1, 8'h80, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[13] = mk(0, 0, 8'h00, 8'h00, 1, 0, 20'h0,     0, 1, 32768,  32767,  -32768, 1, 3'b110);
    tbl[14] = mk(0, 0, 8'h00, 8'h00, 0, 1, 20'h000AB, 1, 1, 171,    171,    171,    1, 3'b000);
    tbl[15] = mk(0, 1, 8'h07, 8'h02, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[16] = mk(0, 0, 8'h00, 8'h00, 0, 0, 20'h0,     0, 1, 171,    171,    171,    1, 3'b000);
    tbl[17] = mk(0, 0, 8'h00, 8'h00, 1, 1, 20'h00055, 1, 1, 14,     14,     14,     1, 3'b000);
    tbl[18] = mk(0, 0, 8'h00, 8'h00, 0, 1, 20'h12345, 0, 1, 74565,  9029,   9029,   0, 3'b000);
    tbl[19] = mk(0, 1, 8'h0A, 8'h0A, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[20] = mk(0, 1, 8'h0A, 8'h0A, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[21] = mk(0, 1, 8'h0A, 8'h0A, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[22] = mk(1, 1, 8'h0A, 8'h0A, 0, 0, 20'h0,     0, 1, 0,      0,      0,      0, 3'b000);
    tbl[23] = mk(0, 0, 8'h00, 8'h00, 1, 0, 20'h0,     0, 1, 0,      0,      0,      1, 3'b000);
    tbl[24] = mk(0, 1, 8'h7F, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[25] = mk(0, 0, 8'h7F, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[26] = mk(0, 1, 8'h7F, 8'h80, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[27] = mk(0, 0, 8'h00, 8'h00, 0, 0, 20'h0,     0, 0, 0,      0,      0,      0, 3'b000);
    tbl[28] = mk(0, 0, 8'h00, 8'h00, 1, 0, 20'h0,     0, 1, -32512, -32512, -32512, 1, 3'b000);

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    drain = 1'b0; shift_en = 1'b0; res_in = '0; res_valid_in = 1'b0;

    for (int i = 0; i < 29; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].drn, tbl[i].shf, tbl[i].rin, tbl[i].rvi);
      checkOutput();
      if (tbl[i].chk) checkTable(tbl[i]);
    end

    $display("[TB] directed vectors done, starting random traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                    8'($urandom), 8'($urandom),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                    20'($urandom), 1'($urandom));
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
